display_frame_ctrl: RTL and testbench
=====================================

# display_frame_ctrl

Frame-synchronous scene controller between game logic and the per-pixel display mux. It accepts position and state snapshots from game logic over a valid/ready handshake and holds them in a pending slot. It commits them to the display only at the start of vertical blanking, so no frame shows a torn update. On scene changes it forces a configurable number of black frames, and it provides a frame counter for sprite animation.

## Interface
Parameters:
- V_ACTIVE, 480: visible lines; `vga_v_cnt >= V_ACTIVE` is vertical blanking.
- BLANK_FRAMES, 16: black frames forced on a scene change, range 1..255.
- POS_W, 9: coordinate width.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, asynchronous, active-high.
- vga_v_cnt  in  10  line counter from the VGA timing generator.
- upd_valid  in  1  game logic presents a snapshot.
- upd_ready  out  1  pending slot is empty; reset value 1.
- state_in  in  4  scene code.
- player_state_in, boss_state_in  in  4 each  sprite pose codes.
- player_x_in, player_y_in, boss_x_in, boss_y_in, obj_x_in, obj_y_in  in  POS_W each  coordinates.
- state_out, player_state_out, boss_state_out  out  4  committed values; reset value 0.
- player_x_out … obj_y_out  out  POS_W  committed coordinates; reset value 0.
- force_blank  out  1  display must output black; reset value 1.
- frame_tick  out  1  one-cycle pulse per frame; reset value 0.
- frame_cnt  out  8  frame counter; reset value 0.

## Operation
- Boundary detection:
  - vb = (vga_v_cnt >= V_ACTIVE). vb_q is vb registered.
  - boundary = vb & ~vb_q, which fires once per frame regardless of the pixel-clock ratio.
- Handshake:
  - A transfer occurs when upd_valid & upd_ready on a clk edge. All *_in values are captured into the pending slot, which becomes full and drives upd_ready low.
  - Game logic may change or drop its inputs freely while upd_ready = 0.
- Commit:
  - At a boundary with the slot full: copy pending to committed and clear the slot.
  - At a boundary with the slot empty: committed values are held.
  - Transfer in the same cycle as a boundary with the slot empty: the snapshot lands in pending and commits at the next boundary. There is no bypass.
- FSM:
  - SYNC (reset state): force_blank = 1. At the first boundary, go to RUN; a pending commit happens normally.
  - RUN: force_blank = 0. At a commit where the new state_in differs from the current state_out, go to BLANK and load blank_cnt = BLANK_FRAMES−1.
  - BLANK: force_blank = 1.
    - At each boundary: if blank_cnt == 0, go to RUN; otherwise decrement blank_cnt.
    - Commits continue during BLANK. A commit carrying a further scene change reloads blank_cnt = BLANK_FRAMES−1.
- frame_cnt increments at every boundary in all states and wraps 255→0.
- Asynchronous reset mid-frame:
  - Discards the pending snapshot and returns to SYNC.
  - The boundary detector restarts: vb_q resets to 1, so no false boundary occurs if reset releases mid-blanking.

## Timing
- All outputs are registered and update on the clk edge that samples boundary = 1:
  - committed values, force_blank, FSM state, frame_cnt
  - frame_tick, high for exactly that following cycle.
- Handshake latency: upd_ready returns to 1 on the edge after the committing boundary.
- Commit latency from a transfer: at most one frame plus one clk.
- Scene-change blanking: force_blank is high for exactly BLANK_FRAMES frames counted from the commit edge. It falls on the edge of the BLANK_FRAMES-th subsequent boundary.
- A 25 MHz pixel clock holds vga_v_cnt for several clk cycles. Edge detection yields exactly one boundary per frame.

## Configuration
- SCENE_BLANK_EN:
  - Defined: RUN→BLANK transitions occur as described.
  - Undefined: the BLANK state and blank_cnt are removed. force_blank is 1 only in SYNC; scene changes commit with no black frames.
- All other behaviour is identical in both builds.

## Structure
- Package display_pkg holds:
  - Scene codes TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8.
  - The FSM state enum {SYNC, RUN, BLANK}.
  - The snapshot struct {state, player_state, boss_state, six coordinates}.
- Sub-module vblank_detect contains vb, vb_q and the boundary pulse, parameterised by V_ACTIVE.

## Test plan
- Reset, then first vblank → force_blank 1→0 at the boundary edge; frame_tick pulses once; frame_cnt = 1.
- Transfer player_x_in = 100 mid-frame with state unchanged → upd_ready = 0; player_x_out is still 0 until the boundary, then 100; upd_ready = 1 on the next cycle.
- Second snapshot offered while the slot is full → not accepted; after the boundary it is accepted and commits one frame later.
- state_in TITLE→STAGE1 with BLANK_FRAMES = 4 and SCENE_BLANK_EN defined → force_blank high for exactly 4 frames; undefined → never high after SYNC.
- Transfer in the same cycle as a boundary with the slot empty → commits at the following boundary, not the current one.
- Assert rst mid-blanking with the slot full → outputs return to reset values; the pending snapshot is never committed; no frame_tick at release.

Source files
------------

// File: rtl/display_pkg.sv
// Shared scene codes, controller FSM states and the game-logic snapshot record
// used by display_frame_ctrl.
package display_pkg;

    typedef enum logic [3:0] {
        TITLE    = 4'd0,
        STAFF    = 4'd1,
        STAGE1   = 4'd2,
        SUCCESS1 = 4'd3,
        STAGE2   = 4'd4,
        SUCCESS2 = 4'd5,
        STAGE3   = 4'd6,
        SUCCESS3 = 4'd7,
        FAIL     = 4'd8
    } scene_e;

    typedef enum logic [1:0] {
        SYNC,
        RUN,
        BLANK
    } fsm_state_e;

    // Coordinates are stored zero-extended to this width; instances use POS_W <= POS_W_MAX.
    localparam int unsigned POS_W_MAX = 12;

    typedef struct packed {
        logic [3:0]           state;
        logic [3:0]           player_state;
        logic [3:0]           boss_state;
        logic [POS_W_MAX-1:0] player_x;
        logic [POS_W_MAX-1:0] player_y;
        logic [POS_W_MAX-1:0] boss_x;
        logic [POS_W_MAX-1:0] boss_y;
        logic [POS_W_MAX-1:0] obj_x;
        logic [POS_W_MAX-1:0] obj_y;
    } snapshot_t;

endpackage

// File: rtl/display_frame_ctrl_vblank_detect.sv
// Start-of-vertical-blanking detector: one boundary pulse per frame, independent
// of how many clk cycles the pixel clock holds each line count.
module vblank_detect #(
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] vga_v_cnt,
    output logic       boundary
);

    logic vb;
    logic vb_q;

    assign vb = (vga_v_cnt >= 10'(V_ACTIVE));

    // Resetting to "in blanking" prevents a false boundary when reset releases mid-blank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vb_q <= 1'b1;
        end else begin
            vb_q <= vb;
        end
    end

    assign boundary = vb & ~vb_q;

endmodule

// File: rtl/display_frame_ctrl.sv
// Frame-synchronous scene controller: buffers game-logic snapshots and commits them
// at the start of vblank. Optional scene-change black frames via SCENE_BLANK_EN.
module display_frame_ctrl
    import display_pkg::*;
#(
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned BLANK_FRAMES = 16,
    parameter int unsigned POS_W        = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       vga_v_cnt,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [3:0]       state_in,
    input  logic [3:0]       player_state_in,
    input  logic [3:0]       boss_state_in,
    input  logic [POS_W-1:0] player_x_in,
    input  logic [POS_W-1:0] player_y_in,
    input  logic [POS_W-1:0] boss_x_in,
    input  logic [POS_W-1:0] boss_y_in,
    input  logic [POS_W-1:0] obj_x_in,
    input  logic [POS_W-1:0] obj_y_in,
    output logic [3:0]       state_out,
    output logic [3:0]       player_state_out,
    output logic [3:0]       boss_state_out,
    output logic [POS_W-1:0] player_x_out,
    output logic [POS_W-1:0] player_y_out,
    output logic [POS_W-1:0] boss_x_out,
    output logic [POS_W-1:0] boss_y_out,
    output logic [POS_W-1:0] obj_x_out,
    output logic [POS_W-1:0] obj_y_out,
    output logic             force_blank,
    output logic             frame_tick,
    output logic [7:0]       frame_cnt
);

    if (BLANK_FRAMES < 1 || BLANK_FRAMES > 255 || POS_W < 1 || POS_W > POS_W_MAX) begin : g_param_check
        $error("display_frame_ctrl: BLANK_FRAMES or POS_W out of range");
    end

    logic       boundary;
    logic       xfer;
    logic       commit;
    logic       pend_full;
    snapshot_t  snap_in;
    snapshot_t  pend;
    snapshot_t  committed;
    fsm_state_e state;
    fsm_state_e state_next;

`ifdef SCENE_BLANK_EN
    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_FRAMES - 1);
    logic       scene_change;
    logic [7:0] blank_cnt;
    logic [7:0] blank_cnt_next;
`endif

    vblank_detect #(
        .V_ACTIVE (V_ACTIVE)
    ) u_vblank_detect (
        .clk       (clk),
        .rst       (rst),
        .vga_v_cnt (vga_v_cnt),
        .boundary  (boundary)
    );

    assign upd_ready = ~pend_full;
    assign xfer      = upd_valid & upd_ready;
    assign commit    = boundary & pend_full;

    always_comb begin
        snap_in              = '0;
        snap_in.state        = state_in;
        snap_in.player_state = player_state_in;
        snap_in.boss_state   = boss_state_in;
        snap_in.player_x     = POS_W_MAX'(player_x_in);
        snap_in.player_y     = POS_W_MAX'(player_y_in);
        snap_in.boss_x       = POS_W_MAX'(boss_x_in);
        snap_in.boss_y       = POS_W_MAX'(boss_y_in);
        snap_in.obj_x        = POS_W_MAX'(obj_x_in);
        snap_in.obj_y        = POS_W_MAX'(obj_y_in);
    end

    // xfer needs an empty slot and commit a full one, so they never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= '0;
            pend_full <= 1'b0;
            committed <= '0;
        end else begin
            if (commit) begin
                committed <= pend;
            end
            if (xfer) begin
                pend      <= snap_in;
                pend_full <= 1'b1;
            end else if (commit) begin
                pend_full <= 1'b0;
            end
        end
    end

`ifdef SCENE_BLANK_EN
    assign scene_change = commit & (pend.state != committed.state);
`endif

    always_comb begin
        state_next = state;
`ifdef SCENE_BLANK_EN
        blank_cnt_next = blank_cnt;
`endif
        if (boundary) begin
            unique case (state)
                SYNC: state_next = RUN;
                RUN: begin
`ifdef SCENE_BLANK_EN
                    if (scene_change) begin
                        state_next     = BLANK;
                        blank_cnt_next = BLANK_LOAD;
                    end
`endif
                end
                BLANK: begin
`ifdef SCENE_BLANK_EN
                    if (scene_change) begin
                        blank_cnt_next = BLANK_LOAD;
                    end else if (blank_cnt == 8'd0) begin
                        state_next = RUN;
                    end else begin
                        blank_cnt_next = blank_cnt - 8'd1;
                    end
`else
                    state_next = RUN;
`endif
                end
                default: state_next = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SYNC;
            force_blank <= 1'b1;
            frame_tick  <= 1'b0;
            frame_cnt   <= '0;
`ifdef SCENE_BLANK_EN
            blank_cnt   <= '0;
`endif
        end else begin
            state       <= state_next;
            force_blank <= (state_next != RUN);
            frame_tick  <= boundary;
            if (boundary) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
`ifdef SCENE_BLANK_EN
            blank_cnt   <= blank_cnt_next;
`endif
        end
    end

    assign state_out        = committed.state;
    assign player_state_out = committed.player_state;
    assign boss_state_out   = committed.boss_state;
    assign player_x_out     = POS_W'(committed.player_x);
    assign player_y_out     = POS_W'(committed.player_y);
    assign boss_x_out       = POS_W'(committed.boss_x);
    assign boss_y_out       = POS_W'(committed.boss_y);
    assign obj_x_out        = POS_W'(committed.obj_x);
    assign obj_y_out        = POS_W'(committed.obj_y);

endmodule

// File: tb/tb_display_frame_ctrl.sv
// Scoreboard bench for display_frame_ctrl on a shortened frame (8 lines, 3 clk per line).
module tb_display_frame_ctrl;
    import display_pkg::*;

    localparam int unsigned V_ACT     = 6;
    localparam int unsigned V_TOTAL   = 8;
    localparam int unsigned LINE_CLKS = 3;
    localparam int unsigned PW        = 9;
`ifdef SCENE_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    vga_v_cnt;
    logic          upd_valid;
    logic          upd_ready;
    logic [3:0]    state_in, player_state_in, boss_state_in;
    logic [PW-1:0] player_x_in, player_y_in, boss_x_in, boss_y_in, obj_x_in, obj_y_in;
    logic [3:0]    state_out, player_state_out, boss_state_out;
    logic [PW-1:0] player_x_out, player_y_out, boss_x_out, boss_y_out, obj_x_out, obj_y_out;
    logic          force_blank;
    logic          frame_tick;
    logic [7:0]    frame_cnt;

    typedef struct {
        logic [7:0] fc;
        logic       fb;
        snapshot_t  snap;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   tick_no = 0;
    bit   gen_on = 1'b0;

    display_frame_ctrl #(
        .V_ACTIVE     (V_ACT),
        .BLANK_FRAMES (4),
        .POS_W        (PW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .vga_v_cnt        (vga_v_cnt),
        .upd_valid        (upd_valid),
        .upd_ready        (upd_ready),
        .state_in         (state_in),
        .player_state_in  (player_state_in),
        .boss_state_in    (boss_state_in),
        .player_x_in      (player_x_in),
        .player_y_in      (player_y_in),
        .boss_x_in        (boss_x_in),
        .boss_y_in        (boss_y_in),
        .obj_x_in         (obj_x_in),
        .obj_y_in         (obj_y_in),
        .state_out        (state_out),
        .player_state_out (player_state_out),
        .boss_state_out   (boss_state_out),
        .player_x_out     (player_x_out),
        .player_y_out     (player_y_out),
        .boss_x_out       (boss_x_out),
        .boss_y_out       (boss_y_out),
        .obj_x_out        (obj_x_out),
        .obj_y_out        (obj_y_out),
        .force_blank      (force_blank),
        .frame_tick       (frame_tick),
        .frame_cnt        (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic snapshot_t mk(input logic [3:0] st, input int unsigned px);
        snapshot_t s;
        s              = '0;
        s.state        = st;
        s.player_state = st + 4'd1;
        s.boss_state   = ~st;
        s.player_x     = POS_W_MAX'(px);
        s.player_y     = POS_W_MAX'(px + 1);
        s.boss_x       = POS_W_MAX'(px + 2);
        s.boss_y       = POS_W_MAX'(px + 3);
        s.obj_x        = POS_W_MAX'(px + 4);
        s.obj_y        = POS_W_MAX'(px + 5);
        return s;
    endfunction

    function automatic snapshot_t cur();
        snapshot_t s;
        s              = '0;
        s.state        = state_out;
        s.player_state = player_state_out;
        s.boss_state   = boss_state_out;
        s.player_x     = POS_W_MAX'(player_x_out);
        s.player_y     = POS_W_MAX'(player_y_out);
        s.boss_x       = POS_W_MAX'(boss_x_out);
        s.boss_y       = POS_W_MAX'(boss_y_out);
        s.obj_x        = POS_W_MAX'(obj_x_out);
        s.obj_y        = POS_W_MAX'(obj_y_out);
        return s;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] fc, input logic fb, input snapshot_t s);
        exp_t e;
        e.fc = fc;
        e.fb = fb;
        e.snap = s;
        q.push_back(e);
    endtask

    task automatic drive(input snapshot_t s);
        state_in        = s.state;
        player_state_in = s.player_state;
        boss_state_in   = s.boss_state;
        player_x_in     = PW'(s.player_x);
        player_y_in     = PW'(s.player_y);
        boss_x_in       = PW'(s.boss_x);
        boss_y_in       = PW'(s.boss_y);
        obj_x_in        = PW'(s.obj_x);
        obj_y_in        = PW'(s.obj_y);
    endtask

    // Caller sits on a negedge with upd_ready high.
    task automatic do_xfer(input snapshot_t s, input string tag);
        drive(s);
        upd_valid = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        check({tag, "_ready_low"}, 128'(upd_ready), 128'(1'b0));
    endtask

    task automatic wait_line(input int unsigned n);
        int unsigned k = 0;
        @(negedge clk);
        while (vga_v_cnt != 10'(n) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (vga_v_cnt != 10'(n)) check($sformatf("wait_line_%0d_timeout", n), 128'(vga_v_cnt), 128'(n));
    endtask

    task automatic wait_tick();
        int unsigned k = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (frame_tick !== 1'b1) check("wait_tick_timeout", 128'(frame_tick), 128'(1'b1));
    endtask

    // Line-counter model of a slow pixel clock: each line held for LINE_CLKS clk cycles.
    initial begin
        vga_v_cnt = '0;
        wait (gen_on);
        forever begin
            for (int unsigned l = 0; l < V_TOTAL; l++) begin
                vga_v_cnt = 10'(l);
                repeat (LINE_CLKS) @(posedge clk);
                #2;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                tick_no++;
                if (q.size() == 0) begin
                    check($sformatf("unexpected_tick_%0d", tick_no), 128'(frame_cnt), 128'(0));
                    if (frame_cnt == 8'd0) begin
                        errors++;
                        $display("FAIL unexpected_tick_%0d: got frame_tick 1, expected 0", tick_no);
                    end
                end else begin
                    e = q.pop_front();
                    check($sformatf("tick%0d_frame_cnt", tick_no), 128'(frame_cnt), 128'(e.fc));
                    check($sformatf("tick%0d_force_blank", tick_no), 128'(force_blank), 128'(e.fb));
                    check($sformatf("tick%0d_snapshot", tick_no), 128'(cur()), 128'(e.snap));
                end
            end
        end
    end

    initial begin
        #100us;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_tick;
        int unsigned k;

        rst       = 1'b1;
        upd_valid = 1'b0;
        drive(mk(TITLE, 0));
        repeat (3) @(negedge clk);
        check("reset_upd_ready", 128'(upd_ready), 128'(1'b1));
        check("reset_force_blank", 128'(force_blank), 128'(1'b1));
        check("reset_frame_tick", 128'(frame_tick), 128'(1'b0));
        check("reset_frame_cnt", 128'(frame_cnt), 128'(0));
        check("reset_snapshot", 128'(cur()), 128'(0));

        push(8'd1, 1'b0, '0);
        rst = 1'b0;
        @(posedge clk);
        #2 gen_on = 1'b1;
        wait_tick();

        // Mid-frame transfer, visible only after the boundary.
        wait_line(2);
        do_xfer(mk(TITLE, 100), "f2_xfer");
        check("f2_px_held", 128'(player_x_out), 128'(0));
        push(8'd2, 1'b0, mk(TITLE, 100));
        wait_tick();
        check("f2_ready_after_commit", 128'(upd_ready), 128'(1'b1));

        // Second offer while the slot is full waits for the boundary.
        wait_line(2);
        do_xfer(mk(TITLE, 200), "f3_xfer");
        push(8'd3, 1'b0, mk(TITLE, 200));
        push(8'd4, 1'b0, mk(TITLE, 300));
        drive(mk(TITLE, 300));
        upd_valid = 1'b1;
        @(negedge clk);
        check("f3_second_not_accepted", 128'(upd_ready), 128'(1'b0));
        k = 0;
        while (upd_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("f3_ready_returns", 128'(upd_ready), 128'(1'b1));
        @(negedge clk);
        upd_valid = 1'b0;
        check("f3_second_accepted", 128'(upd_ready), 128'(1'b0));
        wait_tick();

        // Scene change TITLE -> STAGE1: four black frames when blanking is built in.
        wait_line(2);
        do_xfer(mk(STAGE1, 300), "f5_xfer");
        push(8'd5, BLANK_ON, mk(STAGE1, 300));
        push(8'd6, BLANK_ON, mk(STAGE1, 300));
        push(8'd7, BLANK_ON, mk(STAGE1, 300));
        push(8'd8, BLANK_ON, mk(STAGE1, 300));
        push(8'd9, 1'b0, mk(STAGE1, 300));
        repeat (5) wait_tick();

        // Transfer on the boundary edge itself lands in pending, no bypass.
        wait_line(5);
        wait_line(6);
        drive(mk(STAGE1, 50));
        upd_valid = 1'b1;
        push(8'd10, 1'b0, mk(STAGE1, 300));
        push(8'd11, 1'b0, mk(STAGE1, 50));
        @(negedge clk);
        upd_valid = 1'b0;
        check("f10_boundary_xfer_accepted", 128'(upd_ready), 128'(1'b0));
        check("f10_no_bypass", 128'(player_x_out), 128'(300));
        wait_tick();

        // Enter blanking, fill the slot, then reset mid-frame.
        wait_line(2);
        do_xfer(mk(STAGE2, 77), "f12_xfer");
        push(8'd12, BLANK_ON, mk(STAGE2, 77));
        wait_tick();
        wait_line(2);
        do_xfer(mk(STAGE2, 88), "f13_xfer");
        wait_line(3);
        rst = 1'b1;
        #1;
        check("rst2_upd_ready", 128'(upd_ready), 128'(1'b1));
        check("rst2_force_blank", 128'(force_blank), 128'(1'b1));
        check("rst2_frame_cnt", 128'(frame_cnt), 128'(0));
        check("rst2_frame_tick", 128'(frame_tick), 128'(1'b0));
        check("rst2_snapshot", 128'(cur()), 128'(0));
        wait_line(7);
        rst = 1'b0;
        saw_tick = 1'b0;
        k = 0;
        while (vga_v_cnt != 10'd0 && k < 200) begin
            @(negedge clk);
            if (frame_tick === 1'b1) saw_tick = 1'b1;
            k++;
        end
        check("rst2_no_tick_at_release", 128'(saw_tick), 128'(1'b0));
        push(8'd1, 1'b0, '0);
        wait_tick();
        repeat (2) @(negedge clk);
        check("queue_drained", 128'(q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
